// File: rtl/lfsr_prbs_mon_pkg.sv
// Shared types and width helpers for the PRBS error-statistics monitor.
package lfsr_prbs_mon_pkg;

    typedef enum logic [0:0] {ST_UNLOCKED, ST_LOCKED} mon_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Bits needed to hold a popcount of dw bits (0..dw inclusive).
    function automatic int unsigned pop_width(input int unsigned dw);
        return clog2(dw + 1);
    endfunction

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultPopWidth  = pop_width(DefaultDataWidth);

endpackage

// File: rtl/lfsr_prbs_err_mon_if.sv
// Bus between the PRBS checker side and the error monitor.
interface lfsr_prbs_err_mon_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]  err_in;
    logic                   err_in_valid;
    logic                   clear;
    logic                   locked;
    logic                   lock_lost;
    logic                   err_word;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic [COUNT_WIDTH-1:0] err_count;
    logic                   saturated;

    modport master (
        output err_in, err_in_valid, clear,
        input  locked, lock_lost, err_word, bit_count, err_count, saturated
    );

    modport slave (
        input  err_in, err_in_valid, clear,
        output locked, lock_lost, err_word, bit_count, err_count, saturated
    );
endinterface

// File: rtl/prbs_popcount.sv
// Combinational popcount of a DATA_WIDTH-bit word as a balanced binary adder tree.
module prbs_popcount
    import lfsr_prbs_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic [pop_width(DATA_WIDTH)-1:0] count_o
);
    localparam int unsigned PopW   = pop_width(DATA_WIDTH);
    localparam int unsigned Leaves = 1 << clog2(DATA_WIDTH);
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    // Heap layout: node i sums children 2i+1 and 2i+2; leaves hold the input bits.
    logic [PopW-1:0] node [Nodes];

    always_comb begin
        for (int n = 0; n < int'(Nodes); n++) begin
            node[n] = '0;
        end
        for (int j = 0; j < int'(DATA_WIDTH); j++) begin
            node[int'(Leaves) - 1 + j] = PopW'(data_i[j]);
        end
        for (int i = int'(Leaves) - 2; i >= 0; i--) begin
            node[i] = node[2 * i + 1] + node[2 * i + 2];
        end
    end

    assign count_o = node[0];
endmodule

// File: rtl/lfsr_prbs_err_mon.sv
// Lock tracking and saturating BER counters fed by the PRBS checker error word.
module lfsr_prbs_err_mon
    import lfsr_prbs_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned COUNT_WIDTH   = 32,
    parameter int unsigned LOCK_COUNT    = 64,
    parameter int unsigned WINDOW_WORDS  = 256,
    parameter int unsigned UNLOCK_THRESH = 32
) (
    input logic                clk,
    input logic                rst,
    lfsr_prbs_err_mon_if.slave mon_io
);
    localparam int unsigned PopW  = pop_width(DATA_WIDTH);
    localparam int unsigned CntW1 = COUNT_WIDTH + 1;
    localparam int unsigned RunW  = clog2(LOCK_COUNT + 1);
    localparam int unsigned WinW  = clog2(WINDOW_WORDS + 1);
    localparam int unsigned ErrW  = clog2(UNLOCK_THRESH + 2);

    logic [PopW-1:0] pop_d, pop_q;
    logic            vld_q;

    mon_state_e             state_q;
    logic [RunW-1:0]        clean_q;
    logic [WinW-1:0]        win_words_q;
    logic [ErrW-1:0]        win_errs_q;
    logic [COUNT_WIDTH-1:0] bit_q, bit_d;
    logic [COUNT_WIDTH-1:0] err_q, err_d;
    logic                   sat_q, bit_sat, err_sat;
    logic                   lock_lost_q, err_word_q;

    logic [CntW1-1:0] bit_sum, err_sum;
    logic [31:0]      clean_inc, win_words_inc, win_errs_sum, win_errs_nxt;

    prbs_popcount #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_popcount (
        .data_i  (mon_io.err_in),
        .count_o (pop_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q <= '0;
            vld_q <= 1'b0;
        end else begin
            pop_q <= pop_d;
            vld_q <= mon_io.err_in_valid;
        end
    end

    // Overflowing additions clamp to all-ones; reaching all-ones marks saturation.
    always_comb begin
        bit_sum       = {1'b0, bit_q} + CntW1'(DATA_WIDTH);
        err_sum       = {1'b0, err_q} + CntW1'(pop_q);
        bit_sat       = bit_sum >= {1'b0, {COUNT_WIDTH{1'b1}}};
        err_sat       = err_sum >= {1'b0, {COUNT_WIDTH{1'b1}}};
        bit_d         = bit_sat ? '1 : bit_sum[COUNT_WIDTH-1:0];
        err_d         = err_sat ? '1 : err_sum[COUNT_WIDTH-1:0];
        clean_inc     = 32'(clean_q) + 32'd1;
        win_words_inc = 32'(win_words_q) + 32'd1;
        win_errs_sum  = 32'(win_errs_q) + 32'(pop_q);
        win_errs_nxt  = (win_errs_sum > UNLOCK_THRESH + 1) ? UNLOCK_THRESH + 1 : win_errs_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            clean_q     <= '0;
            win_words_q <= '0;
            win_errs_q  <= '0;
            bit_q       <= '0;
            err_q       <= '0;
            sat_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            err_word_q  <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            err_word_q  <= 1'b0;
            if (mon_io.clear) begin
                bit_q <= '0;
                err_q <= '0;
                sat_q <= 1'b0;
            end
            if (vld_q) begin
                unique case (state_q)
                    ST_UNLOCKED: begin
                        if (pop_q != '0) begin
                            clean_q <= '0;
                        end else if (clean_inc == LOCK_COUNT) begin
                            state_q     <= ST_LOCKED;
                            clean_q     <= '0;
                            win_words_q <= '0;
                            win_errs_q  <= '0;
                        end else begin
                            clean_q <= RunW'(clean_inc);
                        end
                    end
                    ST_LOCKED: begin
                        err_word_q <= (pop_q != '0);
                        if (!mon_io.clear && !sat_q) begin
                            bit_q <= bit_d;
                            err_q <= err_d;
                            sat_q <= bit_sat | err_sat;
                        end
                        if (win_errs_nxt > UNLOCK_THRESH) begin
                            state_q     <= ST_UNLOCKED;
                            lock_lost_q <= 1'b1;
                            win_words_q <= '0;
                            win_errs_q  <= '0;
                        end else if (win_words_inc == WINDOW_WORDS) begin
                            win_words_q <= '0;
                            win_errs_q  <= '0;
                        end else begin
                            win_words_q <= WinW'(win_words_inc);
                            win_errs_q  <= ErrW'(win_errs_nxt);
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign mon_io.locked    = (state_q == ST_LOCKED);
    assign mon_io.lock_lost = lock_lost_q;
    assign mon_io.err_word  = err_word_q;
    assign mon_io.bit_count = bit_q;
    assign mon_io.err_count = err_q;
    assign mon_io.saturated = sat_q;
endmodule
